// File: rtl/exec_hazard_ctrl_if.sv
// Hazard-control bundle between the execute-stage pipeline and exec_hazard_ctrl.
// The master drives the decode/execute status and the slave returns PC-select, stall and flush controls.
interface exec_hazard_ctrl_if #(
  parameter int REG_W = 5
);
  logic             Branch_E;
  logic             Uncond_E;
  logic             BrReg_E;
  logic             zero_E;
  logic             MemRead_E;
  logic [REG_W-1:0] rd_E;
  logic [REG_W-1:0] rs1_D;
  logic [REG_W-1:0] rs2_D;
  logic             useRs2_D;
  logic             dmem_busy;
  logic [1:0]       PCSrc;
  logic             stall_F;
  logic             stall_D;
  logic             stall_E;
  logic             flush_D;
  logic             flush_E;

  modport master (
    output Branch_E, Uncond_E, BrReg_E, zero_E, MemRead_E,
    output rd_E, rs1_D, rs2_D, useRs2_D, dmem_busy,
    input  PCSrc, stall_F, stall_D, stall_E, flush_D, flush_E
  );

  modport slave (
    input  Branch_E, Uncond_E, BrReg_E, zero_E, MemRead_E,
    input  rd_E, rs1_D, rs2_D, useRs2_D, dmem_busy,
    output PCSrc, stall_F, stall_D, stall_E, flush_D, flush_E
  );
endinterface

// File: rtl/exec_hazard_ctrl.sv
// Execute-stage sequencer: branch redirect/flush, load-use bubble and dmem freeze.
// Defining EXEC_HAZARD_PERF_EN adds the ld_stall_cnt / br_flush_cnt event counters.
module exec_hazard_ctrl #(
  parameter int BRANCH_PENALTY = 2,
  parameter int REG_W          = 5,
  parameter int ZR_IDX         = 31
) (
  input  logic                clk,
  input  logic                reset,
  exec_hazard_ctrl_if.slave   hz
`ifdef EXEC_HAZARD_PERF_EN
  ,
  output logic [31:0]         ld_stall_cnt,
  output logic [31:0]         br_flush_cnt
`endif
);

  localparam int CNT_W = (BRANCH_PENALTY > 1) ? $clog2(BRANCH_PENALTY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BRANCH_PENALTY - 1);
  localparam logic [REG_W-1:0] ZR      = REG_W'(ZR_IDX);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    LDSTALL = 2'b01,
    FLUSH   = 2'b10
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;

  logic       taken_s;
  logic       ld_hz_s;
  logic [1:0] target_s;
  logic [1:0] pcsrc_s;
  logic       stall_f_s;
  logic       stall_d_s;
  logic       stall_e_s;
  logic       flush_d_s;
  logic       flush_e_s;

  // Branch-taken and load-use hazard decode; XZR is never a real producer.
  always_comb begin
    taken_s  = hz.Uncond_E | hz.BrReg_E | (hz.Branch_E & hz.zero_E);
    target_s = hz.BrReg_E ? 2'b10 : 2'b01;
    ld_hz_s  = hz.MemRead_E & (hz.rd_E != ZR) &
               ((hz.rd_E == hz.rs1_D) | (hz.useRs2_D & (hz.rd_E == hz.rs2_D)));
  end

  // State and penalty counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= RUN;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state and raw control decode; dmem_busy freezes everything and defers pending work.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    pcsrc_s     = 2'b00;
    stall_f_s   = 1'b0;
    stall_d_s   = 1'b0;
    stall_e_s   = 1'b0;
    flush_d_s   = 1'b0;
    flush_e_s   = 1'b0;
    if (hz.dmem_busy) begin
      stall_f_s = 1'b1;
      stall_d_s = 1'b1;
      stall_e_s = 1'b1;
    end else begin
      case (state_r)
        RUN: begin
          if (taken_s) begin
            pcsrc_s   = target_s;
            flush_d_s = 1'b1;
            flush_e_s = 1'b1;
            if (BRANCH_PENALTY > 1) begin
              state_nxt_s = FLUSH;
              cnt_nxt_s   = CNT_LOAD;
            end else begin
              state_nxt_s = RUN;
            end
          end else if (ld_hz_s) begin
            stall_f_s   = 1'b1;
            stall_d_s   = 1'b1;
            flush_e_s   = 1'b1;
            state_nxt_s = LDSTALL;
          end else begin
            state_nxt_s = RUN;
          end
        end
        LDSTALL: begin
          state_nxt_s = RUN;
        end
        FLUSH: begin
          flush_d_s = 1'b1;
          if (cnt_r == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            state_nxt_s = RUN;
            cnt_nxt_s   = '0;
          end else begin
            cnt_nxt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_nxt_s = RUN;
          cnt_nxt_s   = '0;
        end
      endcase
    end
  end

  // Output drive, forced quiet while reset is asserted.
  always_comb begin
    if (reset) begin
      hz.PCSrc   = 2'b00;
      hz.stall_F = 1'b0;
      hz.stall_D = 1'b0;
      hz.stall_E = 1'b0;
      hz.flush_D = 1'b0;
      hz.flush_E = 1'b0;
    end else begin
      hz.PCSrc   = pcsrc_s;
      hz.stall_F = stall_f_s;
      hz.stall_D = stall_d_s;
      hz.stall_E = stall_e_s;
      hz.flush_D = flush_d_s;
      hz.flush_E = flush_e_s;
    end
  end

`ifdef EXEC_HAZARD_PERF_EN
  logic ld_evt_s;
  logic br_evt_s;

  // Event pulses; both are naturally zero while frozen.
  always_comb begin
    ld_evt_s = (state_r == RUN) & (state_nxt_s == LDSTALL);
    br_evt_s = (state_r == RUN) & ~hz.dmem_busy & taken_s;
  end

  // Wrapping 32-bit event counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_stall_cnt <= 32'd0;
      br_flush_cnt <= 32'd0;
    end else begin
      if (ld_evt_s) begin
        ld_stall_cnt <= ld_stall_cnt + 32'd1;
      end else begin
        ld_stall_cnt <= ld_stall_cnt;
      end
      if (br_evt_s) begin
        br_flush_cnt <= br_flush_cnt + 32'd1;
      end else begin
        br_flush_cnt <= br_flush_cnt;
      end
    end
  end
`else
  // Counters are absent in this build.
`endif

endmodule

// File: tb/tb_exec_hazard_ctrl.sv
// Directed plus randomized check of exec_hazard_ctrl against a penalty/bubble reference model.
// Also covers the EXEC_HAZARD_PERF_EN counters when that macro is defined.
module tb_exec_hazard_ctrl;

  localparam int BP = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  exec_hazard_ctrl_if #(.REG_W(5)) hz ();

`ifdef EXEC_HAZARD_PERF_EN
  logic [31:0] ld_cnt;
  logic [31:0] br_cnt;
`endif

  exec_hazard_ctrl #(
    .BRANCH_PENALTY(BP),
    .REG_W(5),
    .ZR_IDX(31)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hz(hz)
`ifdef EXEC_HAZARD_PERF_EN
    ,
    .ld_stall_cnt(ld_cnt),
    .br_flush_cnt(br_cnt)
`endif
  );

  logic [6:0] obs;
  assign obs = {hz.PCSrc, hz.stall_F, hz.stall_D, hz.stall_E, hz.flush_D, hz.flush_E};

  int checks   = 0;
  int failures = 0;

  // Reference model: redirect penalty cycles still owed, pending bubble, event tallies.
  int          flush_left = 0;
  bit          bubble     = 1'b0;
  logic [31:0] m_ld       = 32'd0;
  logic [31:0] m_br       = 32'd0;
  int          nx_flush;
  bit          nx_bubble;
  logic [31:0] nx_ld;
  logic [31:0] nx_br;

  localparam logic [7:0] NOLIT = 8'h00;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic model(output logic [6:0] e);
    bit         taken;
    bit         ldhz;
    logic [1:0] tgt;
    e         = 7'b0;
    nx_flush  = flush_left;
    nx_bubble = bubble;
    nx_ld     = m_ld;
    nx_br     = m_br;
    taken = (hz.Uncond_E === 1'b1) || (hz.BrReg_E === 1'b1) ||
            ((hz.Branch_E === 1'b1) && (hz.zero_E === 1'b1));
    tgt   = (hz.BrReg_E === 1'b1) ? 2'd2 : 2'd1;
    ldhz  = (hz.MemRead_E === 1'b1) && (hz.rd_E != 5'd31) &&
            ((hz.rd_E == hz.rs1_D) || ((hz.useRs2_D === 1'b1) && (hz.rd_E == hz.rs2_D)));
    if (reset) begin
      flush_left = 0; bubble = 1'b0; m_ld = 32'd0; m_br = 32'd0;
      nx_flush   = 0; nx_bubble = 1'b0; nx_ld = 32'd0; nx_br = 32'd0;
    end else if (hz.dmem_busy) begin
      e = 7'b00_111_00;
    end else if (bubble) begin
      nx_bubble = 1'b0;
    end else if (flush_left > 0) begin
      e = 7'b00_000_10;
      nx_flush = flush_left - 1;
    end else if (taken) begin
      e = {tgt, 5'b000_11};
      nx_flush = BP - 1;
      nx_br = m_br + 32'd1;
    end else if (ldhz) begin
      e = 7'b00_110_01;
      nx_bubble = 1'b1;
      nx_ld = m_ld + 32'd1;
    end
  endtask

  task automatic drive(input logic br, input logic un, input logic brr, input logic z,
                       input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic u2, input logic busy);
    hz.Branch_E  = br;
    hz.Uncond_E  = un;
    hz.BrReg_E   = brr;
    hz.zero_E    = z;
    hz.MemRead_E = mr;
    hz.rd_E      = rd;
    hz.rs1_D     = rs1;
    hz.rs2_D     = rs2;
    hz.useRs2_D  = u2;
    hz.dmem_busy = busy;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0);
  endtask

  // One cycle: settle, compare against model (and optional literal), clock, commit model.
  task automatic step(input string tag, input logic [7:0] lit);
    logic [6:0] e;
    #1;
    model(e);
    chk(tag, {25'd0, obs}, {25'd0, e});
    if (lit[7]) chk({tag, "_lit"}, {25'd0, obs}, {25'd0, lit[6:0]});
`ifdef EXEC_HAZARD_PERF_EN
    chk({tag, "_ldcnt"}, ld_cnt, m_ld);
    chk({tag, "_brcnt"}, br_cnt, m_br);
`endif
    @(posedge clk);
    if (!reset) begin
      flush_left = nx_flush;
      bubble     = nx_bubble;
      m_ld       = nx_ld;
      m_br       = nx_br;
    end
    #1;
  endtask

  function automatic logic [4:0] pick_reg();
    if ($urandom_range(0, 4) == 0) return 5'd31;
    return 5'($urandom_range(0, 3));
  endfunction

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b1);
    @(posedge clk); #1;
    step("rst_busy", {1'b1, 7'b0});
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0);
    step("rst_taken", {1'b1, 7'b0});
    reset = 1'b0;
    idle();
    step("idle", {1'b1, 7'b0});

    // CBZ taken: redirect, one more flush_D, then quiet; branch inputs ignored in FLUSH
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0);
    step("cbz_t0", {1'b1, 7'b01_000_11});
    step("cbz_t1", {1'b1, 7'b00_000_10});
    idle();
    step("cbz_t2", {1'b1, 7'b0});
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0);
    step("cbz_nt", {1'b1, 7'b0});

    // BR and B together: absolute target wins
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0);
    step("abs_t0", {1'b1, 7'b10_000_11});
    idle();
    step("abs_t1", {1'b1, 7'b00_000_10});
    step("abs_t2", {1'b1, 7'b0});

    // Load-use on rs2, then bubble cycle ignores the still-present hazard
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0);
    step("ldu_t0", {1'b1, 7'b00_110_01});
    step("ldu_t1", {1'b1, 7'b0});
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd31, 5'd31, 5'd0, 1'b0, 1'b0);
    step("ldu_xzr", {1'b1, 7'b0});
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0);
    step("ldu_nors2", {1'b1, 7'b0});

    // Taken CBZ frozen three cycles by dmem_busy, redirect on the fourth
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step("busy_hold", {1'b1, 7'b00_111_00});
    hz.dmem_busy = 1'b0;
    step("busy_redir", {1'b1, 7'b01_000_11});
    idle();
    step("busy_t1", {1'b1, 7'b00_000_10});
    step("busy_t2", {1'b1, 7'b0});

    // Reset in FLUSH (cnt=1): quiet at once, then a full pattern after release
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0);
    step("rf_redir", {1'b1, 7'b01_000_11});
    idle();
    reset = 1'b1;
    step("rf_reset", {1'b1, 7'b0});
    reset = 1'b0;
    step("rf_idle", {1'b1, 7'b0});
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0);
    step("rf_t0", {1'b1, 7'b01_000_11});
    idle();
    step("rf_t1", {1'b1, 7'b00_000_10});
    step("rf_t2", {1'b1, 7'b0});

    // Reset in LDSTALL
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 5'd2, 5'd0, 1'b0, 1'b0);
    step("rl_stall", {1'b1, 7'b00_110_01});
    reset = 1'b1;
    step("rl_reset", {1'b1, 7'b0});
    reset = 1'b0;
    step("rl_again", {1'b1, 7'b00_110_01});

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 79) == 0);
      drive(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 11) == 0),
            1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), pick_reg(), pick_reg(), pick_reg(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0));
      step("rand", NOLIT);
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
